// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the processor run sequencer.
package run_ctrl_pkg;

    localparam int unsigned PC_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } run_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: synchronous clear (priority) and enable, async active-low reset.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/run_controller.sv
// Run sequencer: holds the CPU in reset, runs it under a watchdog, captures PC on the
// HALT rising edge, drains for a fixed window and reports DONE; supports re-runs.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES     = 10,
    parameter int unsigned TIMEOUT_CYCLES   = 125000,
    parameter int unsigned POST_HALT_CYCLES = 5,
    parameter int unsigned CNT_WIDTH        = 32,
    parameter int unsigned AUTO_START       = 1
) (
    input  logic                 CLK,
    input  logic                 RST_bar,
    input  logic                 START,
    input  logic                 HALT,
    input  logic [PC_WIDTH-1:0]  PC,
    output logic                 CPU_RST_bar,
    output logic                 RUNNING,
    output logic                 DONE,
    output logic                 TIMED_OUT,
    output logic [CNT_WIDTH-1:0] CYCLES,
    output logic [PC_WIDTH-1:0]  HALT_PC
);

    if (RESET_CYCLES == 0) begin : g_bad_reset_cycles
        $error("run_controller: RESET_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout_cycles
        $error("run_controller: TIMEOUT_CYCLES must be at least 1");
    end

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DRAIN_LAST   =
        CNT_WIDTH'((POST_HALT_CYCLES == 0) ? 0 : POST_HALT_CYCLES - 1);

    run_state_t           state;
    run_state_t           next_state;
    logic                 halt_q;
    logic                 halt_edge;
    logic [CNT_WIDTH-1:0] phase;
    logic                 hold_done;
    logic                 drain_done;
    logic                 timeout_hit;
    logic                 cpu_rst_d;
    logic                 timed_out_d;
    logic                 capture;
    logic                 cyc_clr;
    logic                 cyc_en;

    assign halt_edge   = HALT & ~halt_q;
    assign hold_done   = (phase == HOLD_LAST);
    assign drain_done  = (phase == DRAIN_LAST);
    assign timeout_hit = (CYCLES == TIMEOUT_LAST);

    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if ((AUTO_START != 0) || START) next_state = ST_HOLD;
            ST_HOLD:  if (hold_done) next_state = ST_RUN;
            ST_RUN: begin
                if (halt_edge) begin
                    next_state = (POST_HALT_CYCLES == 0) ? ST_DONE : ST_DRAIN;
                end else if (timeout_hit) begin
                    next_state = ST_DONE;
                end
            end
            ST_DRAIN: if (drain_done) next_state = ST_DONE;
            ST_DONE:  if (START) next_state = ST_HOLD;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_rst_d   = CPU_RST_bar;
        timed_out_d = TIMED_OUT;
        capture     = 1'b0;
        cyc_clr     = 1'b0;
        cyc_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                cpu_rst_d   = 1'b0;
                timed_out_d = 1'b0;
                cyc_clr     = 1'b1;
            end
            ST_HOLD: begin
                cpu_rst_d = hold_done;
                cyc_clr   = 1'b1;
            end
            ST_RUN: begin
                // halt takes priority over the watchdog; both exits freeze CYCLES
                if (halt_edge) begin
                    capture = 1'b1;
                end else if (timeout_hit) begin
                    timed_out_d = 1'b1;
                    cpu_rst_d   = 1'b0;
                end else begin
                    cyc_en = 1'b1;
                end
            end
            ST_DRAIN: cpu_rst_d = 1'b1;
            ST_DONE: begin
                if (START) begin
                    cpu_rst_d   = 1'b0;
                    timed_out_d = 1'b0;
                    cyc_clr     = 1'b1;
                end
            end
            default: cpu_rst_d = 1'b0;
        endcase
    end

    // HOLD and DRAIN share one phase counter, restarted on every state change
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            phase <= '0;
        end else if ((next_state != state) ||
                     !((state == ST_HOLD) || (state == ST_DRAIN))) begin
            phase <= '0;
        end else begin
            phase <= phase + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            halt_q      <= 1'b0;
            CPU_RST_bar <= 1'b0;
            RUNNING     <= 1'b0;
            DONE        <= 1'b0;
            TIMED_OUT   <= 1'b0;
            HALT_PC     <= '0;
        end else begin
            halt_q      <= HALT;
            CPU_RST_bar <= cpu_rst_d;
            RUNNING     <= (next_state == ST_RUN) || (next_state == ST_DRAIN);
            DONE        <= (next_state == ST_DONE);
            TIMED_OUT   <= timed_out_d;
            if (capture) begin
                HALT_PC <= PC;
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_cycles (
        .clk   (CLK),
        .rst_n (RST_bar),
        .clr   (cyc_clr),
        .en    (cyc_en),
        .count (CYCLES)
    );

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: run results are queued as expected when the
// run is stimulated and checked when DONE rises.
module tb_run_controller;

    logic        CLK = 1'b0;
    logic        RST_bar;
    logic        START;
    logic        HALT;
    logic [15:0] PC;
    logic        CPU_RST_bar;
    logic        RUNNING;
    logic        DONE;
    logic        TIMED_OUT;
    logic [31:0] CYCLES;
    logic [15:0] HALT_PC;

    logic        START_B;
    logic        CPU_RST_bar_b;
    logic        RUNNING_b;
    logic        DONE_b;
    logic        TIMED_OUT_b;
    logic [31:0] CYCLES_b;
    logic [15:0] HALT_PC_b;

    typedef struct {
        logic [31:0] cycles;
        logic [15:0] pc;
        logic        timed_out;
        logic        cpu_rst;
    } result_t;

    result_t sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 CLK = ~CLK;

    run_controller #(
        .RESET_CYCLES     (10),
        .TIMEOUT_CYCLES   (100),
        .POST_HALT_CYCLES (5),
        .CNT_WIDTH        (32),
        .AUTO_START       (1)
    ) dut (
        .CLK         (CLK),
        .RST_bar     (RST_bar),
        .START       (START),
        .HALT        (HALT),
        .PC          (PC),
        .CPU_RST_bar (CPU_RST_bar),
        .RUNNING     (RUNNING),
        .DONE        (DONE),
        .TIMED_OUT   (TIMED_OUT),
        .CYCLES      (CYCLES),
        .HALT_PC     (HALT_PC)
    );

    run_controller #(
        .RESET_CYCLES     (10),
        .TIMEOUT_CYCLES   (100),
        .POST_HALT_CYCLES (5),
        .CNT_WIDTH        (32),
        .AUTO_START       (0)
    ) dut_b (
        .CLK         (CLK),
        .RST_bar     (RST_bar),
        .START       (START_B),
        .HALT        (1'b0),
        .PC          (16'h0000),
        .CPU_RST_bar (CPU_RST_bar_b),
        .RUNNING     (RUNNING_b),
        .DONE        (DONE_b),
        .TIMED_OUT   (TIMED_OUT_b),
        .CYCLES      (CYCLES_b),
        .HALT_PC     (HALT_PC_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_result(input string tag);
        result_t e;
        n_checks++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected queued result", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_done"},      64'(DONE),        64'd1);
            chk({tag, "_cycles"},    64'(CYCLES),      64'(e.cycles));
            chk({tag, "_halt_pc"},   64'(HALT_PC),     64'(e.pc));
            chk({tag, "_timed_out"}, 64'(TIMED_OUT),   64'(e.timed_out));
            chk({tag, "_cpu_rst"},   64'(CPU_RST_bar), 64'(e.cpu_rst));
            chk({tag, "_running"},   64'(RUNNING),     64'd0);
        end
    endtask

    initial begin
        RST_bar = 1'b0;
        START   = 1'b0;
        START_B = 1'b0;
        HALT    = 1'b0;
        PC      = 16'h0000;
        step(3);
        chk("rst_cpu_rst",   64'(CPU_RST_bar), 64'd0);
        chk("rst_running",   64'(RUNNING),     64'd0);
        chk("rst_done",      64'(DONE),        64'd0);
        chk("rst_timed_out", 64'(TIMED_OUT),   64'd0);
        chk("rst_cycles",    64'(CYCLES),      64'd0);
        chk("rst_halt_pc",   64'(HALT_PC),     64'd0);

        // Release: one IDLE edge plus ten HOLD edges
        RST_bar = 1'b1;
        step(10);
        chk("t1_cpu_rst_e10", 64'(CPU_RST_bar), 64'd0);
        chk("t1_running_e10", 64'(RUNNING),     64'd0);
        step(1);
        chk("t1_cpu_rst_e11", 64'(CPU_RST_bar), 64'd1);
        chk("t1_running_e11", 64'(RUNNING),     64'd1);
        chk("t1_cycles_e11",  64'(CYCLES),      64'd0);
        chk("t5_autostart0_idle_cpu", 64'(CPU_RST_bar_b), 64'd0);
        chk("t5_autostart0_idle_run", 64'(RUNNING_b),     64'd0);

        // START during RUN is ignored
        step(10);
        START = 1'b1;
        step(1);
        START = 1'b0;
        chk("t5_start_in_run_running", 64'(RUNNING),     64'd1);
        chk("t5_start_in_run_cpu",     64'(CPU_RST_bar), 64'd1);
        chk("t5_start_in_run_cycles",  64'(CYCLES),      64'd11);
        step(26);
        chk("t2_cycles_pre_halt", 64'(CYCLES), 64'd37);

        HALT = 1'b1;
        PC   = 16'h0123;
        sb.push_back('{cycles: 32'd37, pc: 16'h0123, timed_out: 1'b0, cpu_rst: 1'b1});
        step(1);
        chk("t2_drain_running", 64'(RUNNING), 64'd1);
        chk("t2_drain_halt_pc", 64'(HALT_PC), 64'h0123);
        chk("t2_drain_cycles",  64'(CYCLES),  64'd37);
        HALT = 1'b0;
        step(1);
        HALT = 1'b1;
        PC   = 16'h5555;
        step(3);
        chk("t2_done_e4", 64'(DONE), 64'd0);
        step(1);
        check_result("t2_halt");

        // Re-run: HALT still high on RUN entry, so the watchdog fires
        START = 1'b1;
        step(1);
        START = 1'b0;
        chk("t5_rerun_done",    64'(DONE),        64'd0);
        chk("t5_rerun_cycles",  64'(CYCLES),      64'd0);
        chk("t5_rerun_cpu_rst", 64'(CPU_RST_bar), 64'd0);
        chk("t5_rerun_halt_pc", 64'(HALT_PC),     64'h0123);
        step(9);
        chk("t5_hold_e9", 64'(CPU_RST_bar), 64'd0);
        step(1);
        chk("t5_hold_e10", 64'(CPU_RST_bar), 64'd1);
        sb.push_back('{cycles: 32'd99, pc: 16'h0123, timed_out: 1'b1, cpu_rst: 1'b0});
        step(99);
        chk("t3_cycles_99",  64'(CYCLES),  64'd99);
        chk("t3_not_done",   64'(DONE),    64'd0);
        chk("t3_running",    64'(RUNNING), 64'd1);
        step(1);
        check_result("t3_timeout");

        // Halt edge exactly on the timeout cycle
        HALT  = 1'b0;
        START = 1'b1;
        step(1);
        START = 1'b0;
        chk("t4_rerun_timed_out", 64'(TIMED_OUT), 64'd0);
        step(10);
        chk("t4_run_cpu", 64'(CPU_RST_bar), 64'd1);
        step(99);
        chk("t4_cycles_99", 64'(CYCLES), 64'd99);
        HALT = 1'b1;
        PC   = 16'hBEEF;
        sb.push_back('{cycles: 32'd99, pc: 16'hBEEF, timed_out: 1'b0, cpu_rst: 1'b1});
        step(1);
        chk("t4_drain_running",   64'(RUNNING),   64'd1);
        chk("t4_drain_timed_out", 64'(TIMED_OUT), 64'd0);
        chk("t4_drain_halt_pc",   64'(HALT_PC),   64'hBEEF);
        chk("t4_drain_done",      64'(DONE),      64'd0);
        step(5);
        check_result("t4_halt_wins");

        // Another run, then asynchronous reset in the middle of DRAIN
        HALT  = 1'b0;
        START = 1'b1;
        step(1);
        START = 1'b0;
        step(15);
        HALT = 1'b1;
        PC   = 16'h0777;
        step(1);
        chk("t6_drain_running", 64'(RUNNING), 64'd1);
        chk("t6_drain_halt_pc", 64'(HALT_PC), 64'h0777);
        step(2);
        #2;
        RST_bar = 1'b0;
        #1;
        chk("t6_async_cpu_rst", 64'(CPU_RST_bar), 64'd0);
        chk("t6_async_done",    64'(DONE),        64'd0);
        chk("t6_async_running", 64'(RUNNING),     64'd0);
        chk("t6_async_halt_pc", 64'(HALT_PC),     64'd0);
        chk("t6_async_cycles",  64'(CYCLES),      64'd0);
        HALT = 1'b0;
        step(2);
        RST_bar = 1'b1;
        step(10);
        chk("t6_restart_e10", 64'(CPU_RST_bar), 64'd0);
        step(1);
        chk("t6_restart_e11_cpu", 64'(CPU_RST_bar), 64'd1);
        chk("t6_restart_e11_run", 64'(RUNNING),     64'd1);

        // AUTO_START=0 instance waits for START
        chk("t5_b_still_idle", 64'(CPU_RST_bar_b), 64'd0);
        START_B = 1'b1;
        step(1);
        START_B = 1'b0;
        step(9);
        chk("t5_b_hold_e10", 64'(CPU_RST_bar_b), 64'd0);
        step(1);
        chk("t5_b_run_cpu",     64'(CPU_RST_bar_b), 64'd1);
        chk("t5_b_run_running", 64'(RUNNING_b),     64'd1);
        chk("t5_b_run_cycles",  64'(CYCLES_b),      64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
